ex_muldiv: RTL
==============

# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It sits beside the ALU and consumes the forwarded rs/rt operands. It holds the architectural HI/LO registers, which feed the mfhi/mflo result path into the EX/MEM register ahead of the memory stage. The Busy output drives the hazard unit so that dependent md instructions stall in ID.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu (1..15).
- DIV_CYCLES, default 10: busy cycles for div/divu (1..15).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MDOp  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- Busy  out  1  registered; high while an operation is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

## Operation
- Idle (Busy=0) with MDOp 1–4:
  - On the clock edge, latch the computed result into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and set Busy.
- Busy state:
  - Counter decrements each edge.
  - On the edge where counter==1, copy the pending result to HI/LO, clear Busy and clear the counter.
- mult/multu: 64-bit product of A*B, signed or unsigned; HI = [63:32], LO = [31:0].
- div/divu, signed or unsigned:
  - LO = quotient, truncated toward zero.
  - HI = remainder; its sign follows the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B==0): full DIV_CYCLES busy period runs; HI/LO keep their prior values.
- mthi/mtlo while idle: HI or LO ← A at the next edge; the other register is unchanged; Busy stays 0.
- Any nonzero MDOp while Busy=1 is ignored. The hazard unit must stall it; the block does not queue requests.
- MDOp 0 or 7: no effect.
- States:
  - IDLE → RUN on a start op.
  - RUN → RUN while counter > 1.
  - RUN → IDLE on commit.
  - Any state → IDLE on reset.

## Timing
- Reset (reset=0), asynchronous: HI=0, LO=0, Busy=0, counter=0, pending registers=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
  - Release is synchronous to the next edge.
- Start op presented in cycle 0 and sampled at edge E0:
  - Busy=1 in cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO update at edge EN and are visible in cycle N+1, where Busy=0.
- A/B are sampled only at E0; later changes during RUN do not affect the result.
- A new start op presented in cycle N+1 is accepted at that edge, giving back-to-back operations.
- mthi/mtlo have 1-cycle latency: visible the cycle after issue.
- mfhi/mflo read HI/LO combinationally. The hazard unit stalls them while Busy=1 or while MDOp is a start op in the current cycle.
- No combinational path from MDOp/A/B to Busy.

## Structure
- Shared package md_pkg holds:
  - MDOp encodings (MD_NONE … MD_MTLO).
  - Default MULT_CYCLES and DIV_CYCLES.
  - Counter width (4).
- One combinational sub-module, md_calc, computes the {hi, lo} result for ops 1–4. It also outputs a div-by-zero flag, which suppresses commit.
- The top level holds the counter, the FSM, the pending registers and HI/LO.

## Test plan
- mult A=0xFFFFFFFF, B=2 → Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. Signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via mthi/mtlo, then div B=0 → Busy high for 10 cycles, HI=0x11 and LO=0x22 unchanged.
- Start mult, present mtlo A=0x1234 during cycle 2 and divu during cycle 3 → both ignored; final HI/LO equal the mult result. Then mtlo A=0x1234 while idle → LO=0x1234 next cycle, HI unchanged.
- Drive reset=0 in cycle 3 of a div → Busy, HI and LO go to 0 before the next edge. After release, no commit occurs.
- mult issued in the cycle Busy falls after a prior mult → accepted; Busy stays low for exactly one cycle between the two operations and the second result commits 5 cycles later.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide unit.
// Operation codes, cycle defaults, counter width and the debug view of the sequencer.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;
   localparam int MD_CNT_W           = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      md_state_e             state;
      logic [MD_CNT_W-1:0]   cnt;
      logic                  div_zero;
   } md_dbg_t;

   function automatic logic md_is_start(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational product/quotient datapath for mult, multu, div and divu.
// Produces the {hi, lo} result the top level parks in its pending registers.
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div_zero
);

   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic               w_sdiv;
   logic               w_a_neg;
   logic               w_b_neg;
   logic               w_b_zero;
   logic [31:0]        w_ua;
   logic [31:0]        w_ub;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;
   logic [31:0]        w_q;
   logic [31:0]        w_r;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
   always_comb begin
      w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
      w_prod_u = {32'd0, i_a} * {32'd0, i_b};
      w_sdiv   = (i_op == MD_DIV);
      w_a_neg  = w_sdiv && i_a[31];
      w_b_neg  = w_sdiv && i_b[31];
      w_b_zero = (i_b == 32'd0);
      w_ua     = w_a_neg ? -i_a : i_a;
      w_ub     = w_b_neg ? -i_b : i_b;
      w_uq     = w_b_zero ? 32'd0 : (w_ua / w_ub);
      w_ur     = w_b_zero ? 32'd0 : (w_ua % w_ub);
      w_q      = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
      w_r      = w_a_neg ? -w_ur : w_ur;
   end

   always_comb begin
      o_hi       = 32'd0;
      o_lo       = 32'd0;
      o_div_zero = md_is_div(i_op) && w_b_zero;
      case (md_op_e'(i_op))
         MD_MULT:  {o_hi, o_lo} = w_prod_s;
         MD_MULTU: {o_hi, o_lo} = w_prod_u;
         MD_DIV,
         MD_DIVU: begin
            o_hi = w_r;
            o_lo = w_q;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Handshake: a start op is accepted only when Busy=0; any op seen while Busy=1 is dropped, the hazard unit stalls it.
module ex_muldiv
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output md_dbg_t     o_dbg
);

   localparam logic [MD_CNT_W-1:0] L_MULT_CNT = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] L_DIV_CNT  = MD_CNT_W'(DIV_CYCLES);

   md_state_e           r_state;
   md_state_e           w_state_nxt;
   logic [MD_CNT_W-1:0] r_cnt;
   logic [MD_CNT_W-1:0] w_cnt_load;
   logic                r_busy;
   logic [31:0]         r_hi;
   logic [31:0]         r_lo;
   logic [31:0]         r_pend_hi;
   logic [31:0]         r_pend_lo;
   logic                r_pend_dz;
   logic [31:0]         w_calc_hi;
   logic [31:0]         w_calc_lo;
   logic                w_calc_dz;
   logic                w_start;
   logic                w_commit;
   logic                w_wr_hi;
   logic                w_wr_lo;

   md_calc u_calc (
      .i_op       (MDOp),
      .i_a        (A),
      .i_b        (B),
      .o_hi       (w_calc_hi),
      .o_lo       (w_calc_lo),
      .o_div_zero (w_calc_dz)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      w_wr_hi     = 1'b0;
      w_wr_lo     = 1'b0;
      w_cnt_load  = md_is_div(MDOp) ? L_DIV_CNT : L_MULT_CNT;
      case (r_state)
         ST_IDLE: begin
            if (md_is_start(MDOp)) begin
               w_start     = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_wr_hi = (MDOp == MD_MTHI);
               w_wr_lo = (MDOp == MD_MTLO);
            end
         end
         ST_RUN: begin
            if (r_cnt == MD_CNT_W'(1)) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_dz <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         if (w_start) begin
            r_pend_hi <= w_calc_hi;
            r_pend_lo <= w_calc_lo;
            r_pend_dz <= w_calc_dz;
            r_cnt     <= w_cnt_load;
         end else if (w_commit) begin
            r_cnt <= '0;
         end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - MD_CNT_W'(1);
         end
         // A divide by zero still burns its cycles but leaves HI/LO alone.
         if (w_commit && !r_pend_dz) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
         if (w_wr_hi) r_hi <= A;
         if (w_wr_lo) r_lo <= A;
      end
   end

   assign Busy  = r_busy;
   assign HI    = r_hi;
   assign LO    = r_lo;
   assign o_dbg = '{state: r_state, cnt: r_cnt, div_zero: r_pend_dz};

endmodule
